// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor. The ovf signal is present only
// when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow_out, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock.
// Defining SERSUB_OVF_EN adds a registered signed-overflow output (bus.ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, borrow_q, busy_q, done_q;
  logic             d_d, bo_d, last_d;
  logic [WIDTH-1:0] full_d;
`ifdef SERSUB_OVF_EN
  logic             ovf_q;
`endif

  always_comb begin
    d_d    = a_q[0] ^ b_q[0] ^ br_q;
    bo_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_d = (cnt_q == CW'(WIDTH - 1));
    full_d = {d_d, res_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          br_q    <= 1'b0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          res_q <= full_d[WIDTH-1:1];
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= bo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            diff_q   <= full_d;
            borrow_q <= bo_d;
`ifdef SERSUB_OVF_EN
            // a_q[0]/b_q[0] hold the operand sign bits on the final step
            ovf_q    <= (a_q[0] ^ b_q[0]) & (d_d ^ a_q[0]);
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf        = ovf_q;
`endif
endmodule
